// File: rtl/uart_slave.sv
// Byte-wide 8N1 UART slave: CTRL/STATUS and DATA registers on a 4-word bus window,
// fixed baud divisor, per-direction interrupt lines.
module uart_slave #(
    parameter int unsigned DIV = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CS_,
    input  logic        As_,
    input  logic        RW,
    input  logic [1:0]  Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        Rdy_,
    input  logic        Rx,
    output logic        Tx,
    output logic        IRQRx,
    output logic        IRQTx
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'((DIV / 2) - 1);

    logic        rdy_q, rdy_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
    logic        rx_end_q, rx_end_d, tx_end_q, tx_end_d, frame_err_q, frame_err_d;
    logic [7:0]  rx_data_q, rx_data_d;

    logic [1:0]  tx_state_q, tx_state_d;
    logic [15:0] tx_baud_q, tx_baud_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;

    logic [1:0]  sync_q;
    logic        rx_prev_q;
    logic [1:0]  rx_state_q, rx_state_d;
    logic [15:0] rx_baud_q, rx_baud_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;

    logic acc_s, wr_ctrl_s, wr_data_s, tx_done_s, rx_done_s, rx_ferr_s, rx_bit_s;
    logic tx_busy_s, rx_busy_s;
    logic wr_unused_s;

    assign acc_s       = !CS_ && !As_ && rdy_q;
    assign wr_ctrl_s   = acc_s && !RW && (Addr == 2'd0);
    assign wr_data_s   = acc_s && !RW && (Addr == 2'd1);
    assign tx_busy_s   = (tx_state_q != S_IDLE);
    assign rx_busy_s   = (rx_state_q != S_IDLE);
    assign rx_bit_s    = sync_q[1];
    assign wr_unused_s = ^WrData[31:8];

    assign Rdy_   = rdy_q;
    assign RdData = rd_data_q;
    assign Tx     = tx_q;
    assign IRQRx  = rx_end_q & rx_ie_q;
    assign IRQTx  = tx_end_q & tx_ie_q;

    // Transmit FSM; Tx is registered from the next state so it changes on the accepting edge.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_done_s  = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                if (wr_data_s) begin
                    tx_state_d = S_START;
                    tx_baud_d  = 16'd0;
                    tx_bit_d   = 3'd0;
                    tx_shift_d = WrData[7:0];
                end else begin
                    tx_state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tx_baud_q == DIV_M1) begin
                    tx_state_d = S_DATA;
                    tx_baud_d  = 16'd0;
                end else begin
                    tx_baud_d = tx_baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (tx_baud_q == DIV_M1) begin
                    tx_baud_d = 16'd0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_baud_d = tx_baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (tx_baud_q == DIV_M1) begin
                    tx_state_d = S_IDLE;
                    tx_baud_d  = 16'd0;
                    tx_done_s  = 1'b1;
                end else begin
                    tx_baud_d = tx_baud_q + 16'd1;
                end
            end
            default: begin
                tx_state_d = S_IDLE;
                tx_baud_d  = 16'd0;
            end
        endcase
        case (tx_state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = tx_shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Receive FSM: half-bit wait to the start-bit centre, then whole-bit steps.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done_s  = 1'b0;
        rx_ferr_s  = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_bit_s) begin
                    rx_state_d = S_START;
                    rx_baud_d  = 16'd0;
                end else begin
                    rx_state_d = S_IDLE;
                end
            end
            S_START: begin
                if (rx_baud_q == HALF_M1) begin
                    rx_baud_d = 16'd0;
                    rx_bit_d  = 3'd0;
                    if (!rx_bit_s) begin
                        rx_state_d = S_DATA;
                    end else begin
                        rx_state_d = S_IDLE;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (rx_baud_q == DIV_M1) begin
                    rx_baud_d  = 16'd0;
                    rx_shift_d = {rx_bit_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (rx_baud_q == DIV_M1) begin
                    rx_baud_d  = 16'd0;
                    rx_state_d = S_IDLE;
                    if (rx_bit_s) begin
                        rx_done_s = 1'b1;
                    end else begin
                        rx_ferr_s = 1'b1;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + 16'd1;
                end
            end
            default: begin
                rx_state_d = S_IDLE;
                rx_baud_d  = 16'd0;
            end
        endcase
    end

    // Bus ack, read mux and flag updates; a hardware set beats a same-cycle W1C.
    always_comb begin
        rdy_d     = !acc_s;
        rd_data_d = 32'd0;
        if (acc_s && RW) begin
            case (Addr)
                2'd0:    rd_data_d = {25'd0, frame_err_q, rx_busy_s, tx_busy_s,
                                      tx_end_q, rx_end_q, tx_ie_q, rx_ie_q};
                2'd1:    rd_data_d = {24'd0, rx_data_q};
                default: rd_data_d = 32'd0;
            endcase
        end else begin
            rd_data_d = 32'd0;
        end
        if (wr_ctrl_s) begin
            rx_ie_d = WrData[0];
            tx_ie_d = WrData[1];
        end else begin
            rx_ie_d = rx_ie_q;
            tx_ie_d = tx_ie_q;
        end
        rx_end_d    = (rx_end_q    & ~(wr_ctrl_s & WrData[2])) | rx_done_s;
        tx_end_d    = (tx_end_q    & ~(wr_ctrl_s & WrData[3])) | tx_done_s;
        frame_err_d = (frame_err_q & ~(wr_ctrl_s & WrData[6])) | rx_ferr_s;
        rx_data_d   = rx_done_s ? rx_shift_q : rx_data_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_q       <= 1'b1;
            rd_data_q   <= 32'd0;
            rx_ie_q     <= 1'b0;
            tx_ie_q     <= 1'b0;
            rx_end_q    <= 1'b0;
            tx_end_q    <= 1'b0;
            frame_err_q <= 1'b0;
            rx_data_q   <= 8'd0;
            tx_state_q  <= S_IDLE;
            tx_baud_q   <= 16'd0;
            tx_bit_q    <= 3'd0;
            tx_shift_q  <= 8'd0;
            tx_q        <= 1'b1;
            sync_q      <= 2'b11;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_baud_q   <= 16'd0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'd0;
        end else begin
            rdy_q       <= rdy_d;
            rd_data_q   <= rd_data_d;
            rx_ie_q     <= rx_ie_d;
            tx_ie_q     <= tx_ie_d;
            rx_end_q    <= rx_end_d;
            tx_end_q    <= tx_end_d;
            frame_err_q <= frame_err_d;
            rx_data_q   <= rx_data_d;
            tx_state_q  <= tx_state_d;
            tx_baud_q   <= tx_baud_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            sync_q      <= {sync_q[0], Rx};
            rx_prev_q   <= sync_q[1];
            rx_state_q  <= rx_state_d;
            rx_baud_q   <= rx_baud_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
        end
    end

endmodule

// File: tb/tb_uart_slave.sv
// Self-checking bench for uart_slave at DIV=4: random bytes in both directions
// compared against a frame-level model of the register file and serial line.
module tb_uart_slave;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset, CS_, As_, RW, Rx;
    logic [1:0]  Addr;
    logic [31:0] WrData, RdData;
    logic        Rdy_, Tx, IRQRx, IRQTx;

    int n_checks = 0;
    int n_errors = 0;

    logic       m_rx_ie, m_tx_ie, m_rx_end, m_tx_end, m_ferr;
    logic [7:0] m_rx_data;

    uart_slave #(.DIV(DIV)) dut (
        .clk(clk), .reset(reset), .CS_(CS_), .As_(As_), .RW(RW), .Addr(Addr),
        .WrData(WrData), .RdData(RdData), .Rdy_(Rdy_), .Rx(Rx), .Tx(Tx),
        .IRQRx(IRQRx), .IRQTx(IRQTx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {25'd0, m_ferr, 1'b0, 1'b0, m_tx_end, m_rx_end, m_tx_ie, m_rx_ie};
    endfunction

    task automatic m_reset();
        m_rx_ie = 1'b0; m_tx_ie = 1'b0; m_rx_end = 1'b0; m_tx_end = 1'b0;
        m_ferr = 1'b0; m_rx_data = 8'd0;
    endtask

    // One bus access; returns one cycle after the ack so the next call is a fresh access.
    task automatic bus_access(input logic rw, input logic [1:0] a, input logic [31:0] wd,
                              output logic [31:0] rd);
        CS_ = 1'b0; As_ = 1'b0; RW = rw; Addr = a; WrData = wd;
        @(posedge clk); #1;
        chk("ack_low", {31'd0, Rdy_}, 32'd0);
        rd = RdData;
        CS_ = 1'b1; As_ = 1'b1; RW = 1'b1; WrData = 32'd0;
        @(posedge clk); #1;
        chk("ack_release", {31'd0, Rdy_}, 32'd1);
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        bus_access(1'b1, a, 32'd0, rd);
        chk(tag, rd, exp);
    endtask

    task automatic ctrl_write(input logic [31:0] d);
        logic [31:0] rd;
        bus_access(1'b0, 2'd0, d, rd);
        m_rx_ie = d[0];
        m_tx_ie = d[1];
        if (d[2]) m_rx_end = 1'b0;
        if (d[3]) m_tx_end = 1'b0;
        if (d[6]) m_ferr = 1'b0;
        chk("irq_rx", {31'd0, IRQRx}, {31'd0, m_rx_end & m_rx_ie});
        chk("irq_tx", {31'd0, IRQTx}, {31'd0, m_tx_end & m_tx_ie});
    endtask

    // Starts one cycle after the accepting edge A; bit i owns edges A+4i..A+4i+3.
    task automatic check_tx_frame(input logic [7:0] d);
        logic [10:0] bits;
        int cur;
        bits = {1'b1, 1'b1, d, 1'b0};
        cur = 0;
        for (int i = 0; i < 10; i++) begin
            repeat (DIV * i + DIV - 2 - cur) @(posedge clk);
            #1;
            cur = DIV * i + DIV - 2;
            chk($sformatf("tx_bit%0d_end", i), {31'd0, Tx}, {31'd0, bits[i]});
            @(posedge clk); #1;
            cur++;
            chk($sformatf("tx_bit%0d_next", i + 1), {31'd0, Tx}, {31'd0, bits[i+1]});
        end
    endtask

    task automatic tx_send(input logic [7:0] d);
        logic [31:0] rd;
        bus_access(1'b0, 2'd1, {24'd0, d}, rd);
        check_tx_frame(d);
        m_tx_end = 1'b1;
        read_check("tx_status", 2'd0, m_status());
        chk("irq_tx_after", {31'd0, IRQTx}, {31'd0, m_tx_end & m_tx_ie});
    endtask

    // Drives a frame from a negedge; returns at the negedge before the stop-sample edge.
    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        @(negedge clk);
        for (int j = 0; j < 10; j++) begin
            Rx = fr[j];
            repeat (DIV) @(negedge clk);
        end
        Rx = 1'b1;
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop);
        send_rx(d, stop);
        repeat (3) @(negedge clk);
        if (stop) begin
            m_rx_data = d;
            m_rx_end  = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
        read_check("rx_data", 2'd1, {24'd0, m_rx_data});
        read_check("rx_status", 2'd0, m_status());
        chk("irq_rx_after", {31'd0, IRQRx}, {31'd0, m_rx_end & m_rx_ie});
    endtask

    task automatic quiet_tx(input string tag, input int cycles);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (Tx !== 1'b1) lows++;
        end
        chk(tag, lows, 0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  d;
        logic        stop;
        int          pulses, rd_leak;

        reset = 1'b1; CS_ = 1'b1; As_ = 1'b1; RW = 1'b1; Addr = 2'd0; WrData = 32'd0; Rx = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx", {31'd0, Tx}, 32'd1);
        chk("rst_rdy", {31'd0, Rdy_}, 32'd1);
        chk("rst_rddata", RdData, 32'd0);
        chk("rst_irq", {30'd0, IRQRx, IRQTx}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        read_check("rst_status", 2'd0, 32'd0);
        read_check("rst_rxdata", 2'd1, 32'd0);
        read_check("addr2", 2'd2, 32'd0);

        // Transmit path
        tx_send(8'hA5);
        ctrl_write(32'h0000_0002);
        read_check("tx_ie_status", 2'd0, m_status());
        ctrl_write(32'h0000_000A);

        ctrl_write(32'h0000_0000);
        bus_access(1'b0, 2'd1, 32'h0000_003C, rd);
        fork
            check_tx_frame(8'h3C);
            begin
                logic [31:0] rd2;
                repeat (8) @(negedge clk);
                bus_access(1'b0, 2'd1, 32'h0000_00FF, rd2);
                bus_access(1'b1, 2'd0, 32'd0, rd2);
                chk("tx_busy_flag", {31'd0, rd2[4]}, 32'd1);
            end
        join
        m_tx_end = 1'b1;
        read_check("busy_status", 2'd0, m_status());
        ctrl_write(32'h0000_0008);
        quiet_tx("tx_dropped_quiet", 60);
        read_check("tx_once_status", 2'd0, m_status());

        for (int i = 0; i < 3; i++) begin
            ctrl_write({30'd0, 1'($urandom_range(0, 1)), 1'b0});
            tx_send(8'($urandom));
            ctrl_write(32'h0000_0008);
        end

        // Receive path
        ctrl_write(32'h0000_0001);
        rx_frame(8'h5A, 1'b1);
        ctrl_write(32'h0000_0004);
        read_check("rx_w1c", 2'd0, m_status());

        @(negedge clk); Rx = 1'b0;
        @(negedge clk); Rx = 1'b1;
        repeat (12) @(negedge clk);
        read_check("glitch_status", 2'd0, m_status());
        read_check("glitch_data", 2'd1, {24'd0, m_rx_data});

        rx_frame(8'h81, 1'b0);
        ctrl_write(32'h0000_0040);

        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            ctrl_write({31'd0, 1'($urandom_range(0, 1))});
            rx_frame(d, stop);
            ctrl_write(32'h0000_0044);
        end

        // rx_end set on the same edge as its W1C
        d = 8'($urandom);
        send_rx(d, 1'b1);
        bus_access(1'b0, 2'd0, 32'h0000_0004, rd);
        m_rx_ie = 1'b0; m_rx_end = 1'b1; m_rx_data = d;
        read_check("set_wins", 2'd0, m_status());
        read_check("set_wins_data", 2'd1, {24'd0, m_rx_data});

        // Reset in the middle of a transmit
        bus_access(1'b0, 2'd1, 32'h0000_0055, rd);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midtx_reset_tx", {31'd0, Tx}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        m_reset();
        quiet_tx("midtx_quiet", 50);
        read_check("midtx_status", 2'd0, m_status());
        read_check("midtx_rxdata", 2'd1, 32'd0);

        // Address strobe held low through the ack cycle
        pulses = 0;
        rd_leak = 0;
        @(negedge clk);
        CS_ = 1'b0; As_ = 1'b0; RW = 1'b1; Addr = 2'd1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (Rdy_ === 1'b0) pulses++;
            if (Rdy_ === 1'b1 && RdData !== 32'd0) rd_leak++;
            if (i == 1) begin
                CS_ = 1'b1; As_ = 1'b1;
            end
        end
        chk("held_as_pulses", pulses, 1);
        chk("rddata_idle_zero", rd_leak, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
